// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback wrapper around the combinational MIPS ALU.
// D decodes opcode/funct into aluc and operands and drives the ALU; W captures
// the ALU result and presents one writeback beat per accepted instruction.
// Optional feature macro: ALU_ISSUE_TRAP_EN (overflow trap on add/sub/addi).
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wb_en,
  output logic [4:0]  out_wb_addr,
  output logic [31:0] out_wb_data,
  output logic        out_illegal,
  output logic [31:0] out_pc,
  output logic        trap_valid,
  output logic [31:0] trap_epc
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1110;
  localparam logic [3:0] ALUC_SLL  = 4'b1111;

  // instruction fields
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [RW-1:0] rt_idx;
  logic [RW-1:0] rd_idx;
  logic [RW-1:0] shamt;
  logic [15:0]   imm;
  logic [DW-1:0] imm_sx;
  logic [DW-1:0] imm_zx;

  assign opcode = in_instr[31:26];
  assign rt_idx = in_instr[20:16];
  assign rd_idx = in_instr[15:11];
  assign shamt  = in_instr[10:6];
  assign funct  = in_instr[5:0];
  assign imm    = in_instr[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};

  // decode results
  logic [3:0]    dec_aluc;
  logic [DW-1:0] dec_a;
  logic [DW-1:0] dec_b;
  logic [RW-1:0] dec_dest;
  logic          dec_illegal;
  logic          dec_ovf_en;
  logic          dec_wb_en;

  // D stage
  logic          d_valid;
  logic [3:0]    d_aluc;
  logic [DW-1:0] d_a;
  logic [DW-1:0] d_b;
  logic [RW-1:0] d_dest;
  logic          d_wb_en;
  logic          d_illegal;
  logic          d_ovf_en;
  logic [DW-1:0] d_pc;

  // W stage
  logic          w_valid;
  logic          w_wb_en;
  logic [RW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_illegal;
  logic [DW-1:0] w_pc;

  logic advance;
  logic ovf_hit;

  assign advance  = ~w_valid | out_ready;
  assign in_ready = ~d_valid | advance;

  // translate opcode/funct into aluc, operands, destination and legality
  always_comb begin
    dec_aluc    = ALUC_ADDU;
    dec_a       = '0;
    dec_b       = '0;
    dec_dest    = '0;
    dec_illegal = 1'b1;
    dec_ovf_en  = 1'b0;
    if (opcode == 6'h00) begin
      dec_illegal = 1'b0;
      dec_a       = in_rs;
      dec_b       = in_rt;
      dec_dest    = rd_idx;
      case (funct)
        6'h20: begin dec_aluc = ALUC_ADD; dec_ovf_en = 1'b1; end
        6'h21: dec_aluc = ALUC_ADDU;
        6'h22: begin dec_aluc = ALUC_SUB; dec_ovf_en = 1'b1; end
        6'h23: dec_aluc = ALUC_SUBU;
        6'h24: dec_aluc = ALUC_AND;
        6'h25: dec_aluc = ALUC_OR;
        6'h26: dec_aluc = ALUC_XOR;
        6'h27: dec_aluc = ALUC_NOR;
        6'h2A: dec_aluc = ALUC_SLT;
        6'h2B: dec_aluc = ALUC_SLTU;
        6'h00: begin dec_aluc = ALUC_SLL; dec_a = {27'b0, shamt}; end
        6'h04: begin dec_aluc = ALUC_SLL; dec_a = {27'b0, in_rs[4:0]}; end
        6'h02: begin dec_aluc = ALUC_SRL; dec_a = {27'b0, shamt}; end
        6'h06: begin dec_aluc = ALUC_SRL; dec_a = {27'b0, in_rs[4:0]}; end
        6'h03: begin dec_aluc = ALUC_SRA; dec_a = {27'b0, shamt}; end
        6'h07: begin dec_aluc = ALUC_SRA; dec_a = {27'b0, in_rs[4:0]}; end
        default: begin
          dec_illegal = 1'b1;
          dec_a       = '0;
          dec_b       = '0;
          dec_dest    = '0;
        end
      endcase
    end else begin
      dec_illegal = 1'b0;
      dec_a       = in_rs;
      dec_b       = imm_sx;
      dec_dest    = rt_idx;
      case (opcode)
        6'h08: begin dec_aluc = ALUC_ADD; dec_ovf_en = 1'b1; end
        6'h09: dec_aluc = ALUC_ADDU;
        6'h0A: dec_aluc = ALUC_SLT;
        6'h0B: dec_aluc = ALUC_SLTU;
        6'h0C: begin dec_aluc = ALUC_AND; dec_b = imm_zx; end
        6'h0D: begin dec_aluc = ALUC_OR;  dec_b = imm_zx; end
        6'h0E: begin dec_aluc = ALUC_XOR; dec_b = imm_zx; end
        6'h0F: begin dec_aluc = ALUC_LUI; dec_b = imm_zx; end
        default: begin
          dec_illegal = 1'b1;
          dec_a       = '0;
          dec_b       = '0;
          dec_dest    = '0;
        end
      endcase
    end
  end

  assign dec_wb_en = ~dec_illegal & (dec_dest != 5'd0);

  // D register: load on input handshake, empty when its beat moves to W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid   <= 1'b0;
      d_aluc    <= ALUC_ADDU;
      d_a       <= '0;
      d_b       <= '0;
      d_dest    <= '0;
      d_wb_en   <= 1'b0;
      d_illegal <= 1'b0;
      d_ovf_en  <= 1'b0;
      d_pc      <= '0;
    end else if (in_valid && in_ready) begin
      d_valid   <= 1'b1;
      d_aluc    <= dec_aluc;
      d_a       <= dec_a;
      d_b       <= dec_b;
      d_dest    <= dec_dest;
      d_wb_en   <= dec_wb_en;
      d_illegal <= dec_illegal;
      d_ovf_en  <= dec_ovf_en;
      d_pc      <= in_pc;
    end else if (advance) begin
      d_valid <= 1'b0;
    end
  end

  assign alu_a    = d_a;
  assign alu_b    = d_b;
  assign alu_aluc = d_aluc;

`ifdef ALU_ISSUE_TRAP_EN
  logic          w_trap;
  logic [DW-1:0] epc_q;

  assign ovf_hit = d_ovf_en & alu_overflow;

  // trap flag travels with the beat in W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_trap <= 1'b0;
    end else if (advance) begin
      w_trap <= d_valid & ovf_hit;
    end
  end

  // EPC latches the PC of a trapped beat as it leaves W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= '0;
    end else if (w_valid && out_ready && w_trap) begin
      epc_q <= w_pc;
    end
  end

  assign trap_valid = w_trap;
  assign trap_epc   = epc_q;
`else
  logic unused_ovf;

  assign ovf_hit    = 1'b0;
  assign unused_ovf = &{1'b0, alu_overflow, d_ovf_en};
  assign trap_valid = 1'b0;
  assign trap_epc   = '0;
`endif

  // W register: capture ALU result whenever the output slot can advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid   <= 1'b0;
      w_wb_en   <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      w_illegal <= 1'b0;
      w_pc      <= '0;
    end else if (advance) begin
      w_valid   <= d_valid;
      w_wb_en   <= d_valid & d_wb_en & ~ovf_hit;
      w_addr    <= d_dest;
      w_data    <= alu_r;
      w_illegal <= d_valid & d_illegal;
      w_pc      <= d_pc;
    end
  end

  assign out_valid   = w_valid;
  assign out_wb_en   = w_wb_en;
  assign out_wb_addr = w_addr;
  assign out_wb_data = w_data;
  assign out_illegal = w_illegal;
  assign out_pc      = w_pc;

endmodule
